// File: rtl/obi_sram_shim.sv
// obi_sram_shim: terminal OBI subordinate driving a fixed-latency single-port SRAM macro
package obi_pkg;
  typedef struct packed {
    logic UseAtop;
  } obi_optional_cfg_t;
  typedef struct packed {
    logic        UseRReady;
    logic        Integrity;
    int unsigned AddrWidth;
    int unsigned DataWidth;
    int unsigned IdWidth;
    obi_optional_cfg_t OptionalCfg;
  } obi_cfg_t;
  localparam obi_cfg_t ObiDefaultConfig = '{
    UseRReady: 1'b1, Integrity: 1'b0, AddrWidth: 32, DataWidth: 32, IdWidth: 4,
    OptionalCfg: '{UseAtop: 1'b0}
  };
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [3:0]  aid;
    logic [5:0]  atop;
  } obi_a_chan_t;
  typedef struct packed {
    logic        req;
    logic        rready;
    obi_a_chan_t a;
  } obi_req_t;
  typedef struct packed {
    logic [31:0] rdata;
    logic [3:0]  rid;
    logic        err;
    logic        exokay;
  } obi_r_chan_t;
  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    obi_r_chan_t r;
  } obi_rsp_t;
endpackage

module obi_sram_shim #(
  parameter obi_pkg::obi_cfg_t ObiCfg = obi_pkg::ObiDefaultConfig,
  parameter type obi_req_t = obi_pkg::obi_req_t,
  parameter type obi_rsp_t = obi_pkg::obi_rsp_t,
  parameter int unsigned SramLatency = 1,
  parameter int unsigned RspFifoDepth = SramLatency + 1
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  obi_req_t                        obi_req_i,
  output obi_rsp_t                        obi_rsp_o,
  output logic                            req_o,
  output logic                            we_o,
  output logic [ObiCfg.AddrWidth-1:0]     addr_o,
  output logic [ObiCfg.DataWidth-1:0]     wdata_o,
  output logic [ObiCfg.DataWidth/8-1:0]   be_o,
  input  logic [ObiCfg.DataWidth-1:0]     rdata_i
);
  if (ObiCfg.Integrity) begin : g_integrity_err
    $error("obi_sram_shim: Integrity must be 0");
  end
  if (SramLatency < 1 || SramLatency > 4) begin : g_latency_err
    $error("obi_sram_shim: SramLatency must be 1..4");
  end
  if (RspFifoDepth < 1) begin : g_depth_err
    $error("obi_sram_shim: RspFifoDepth must be >= 1");
  end

  localparam int unsigned CntW = $clog2(RspFifoDepth + 1);
  localparam int unsigned PtrW = RspFifoDepth > 1 ? $clog2(RspFifoDepth) : 1;
  localparam int unsigned IdW  = ObiCfg.IdWidth;
  localparam int unsigned DW   = ObiCfg.DataWidth;

  typedef struct packed {
    logic           v;
    logic [IdW-1:0] id;
    logic           we;
    logic           err;
  } trk_t;
  typedef struct packed {
    logic [DW-1:0]  rdata;
    logic [IdW-1:0] id;
    logic           err;
  } ent_t;

  trk_t            pipe [SramLatency];
  ent_t            fifo_q [RspFifoDepth];
  logic [PtrW-1:0] wptr, rptr;
  logic [CntW-1:0] fcnt, cnt;
  logic            gnt, atop_err, push, pop, empty, store, deq, rready, rvalid;
  trk_t            exit_s;
  ent_t            push_e, head;

  function automatic logic [PtrW-1:0] inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(RspFifoDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  // Grant only counts what is already committed; pops this cycle are not credited so rready never reaches gnt.
  assign atop_err = ObiCfg.OptionalCfg.UseAtop && (obi_req_i.a.atop != '0);
  assign gnt      = rst_ni && obi_req_i.req && (cnt < CntW'(RspFifoDepth));
  assign req_o    = gnt && !atop_err;
  assign we_o     = req_o && obi_req_i.a.we;
  assign addr_o   = obi_req_i.a.addr;
  assign wdata_o  = obi_req_i.a.wdata;
  assign be_o     = obi_req_i.a.be;

  assign exit_s = pipe[SramLatency-1];
  assign push   = exit_s.v;
  assign empty  = (fcnt == '0);
  assign rready = ObiCfg.UseRReady ? obi_req_i.rready : 1'b1;
  assign rvalid = !empty || push;
  assign pop    = rvalid && rready;
  assign store  = push && !(empty && pop);
  assign deq    = pop && !empty;
  assign head   = empty ? push_e : fifo_q[rptr];

  // Build the FIFO entry from the exiting stage; writes and rejected atomics return zero data.
  always_comb begin
    push_e       = '0;
    push_e.id    = exit_s.id;
    push_e.err   = exit_s.err;
    push_e.rdata = (exit_s.v && !exit_s.we && !exit_s.err) ? rdata_i : '0;
  end

  // Assemble the OBI response; the FIFO falls through when empty.
  always_comb begin
    obi_rsp_o          = '0;
    obi_rsp_o.gnt      = gnt;
    obi_rsp_o.rvalid   = rvalid;
    obi_rsp_o.r.rdata  = head.rdata;
    obi_rsp_o.r.rid    = head.id;
    obi_rsp_o.r.err    = head.err;
    obi_rsp_o.r.exokay = 1'b0;
  end

  // Tracking pipeline mirrors the SRAM latency and never stalls.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < SramLatency; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= '{v: gnt, id: obi_req_i.a.aid, we: obi_req_i.a.we, err: atop_err};
      for (int i = 1; i < SramLatency; i++) pipe[i] <= pipe[i-1];
    end
  end

  // FIFO pointers, occupancy and the total pending count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr <= '0;
      rptr <= '0;
      fcnt <= '0;
      cnt  <= '0;
    end else begin
      if (store) wptr <= inc(wptr);
      if (deq) rptr <= inc(rptr);
      fcnt <= fcnt + CntW'(store) - CntW'(deq);
      cnt  <= cnt + CntW'(gnt) - CntW'(pop);
    end
  end

  // FIFO storage captures rdata_i on push so it survives backpressure.
  always_ff @(posedge clk_i) begin
    if (store) fifo_q[wptr] <= push_e;
  end

  a_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    obi_req_i.req && !gnt |=> $stable(obi_req_i.a));
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
    pop |-> (!empty || push));
  a_cnt_max: assert property (@(posedge clk_i) disable iff (!rst_ni)
    cnt <= CntW'(RspFifoDepth));
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(store && !deq && fcnt == CntW'(RspFifoDepth)));
endmodule

// File: tb/tb_obi_sram_shim.sv
// tb_obi_sram_shim: directed checks of the OBI-to-SRAM shim on two configurations
module tb_obi_sram_shim;
  import obi_pkg::*;

  localparam obi_cfg_t Cfg1 = '{
    UseRReady: 1'b1, Integrity: 1'b0, AddrWidth: 32, DataWidth: 32, IdWidth: 4,
    OptionalCfg: '{UseAtop: 1'b1}
  };

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  obi_req_t q1, q2;
  obi_rsp_t s1, s2;
  logic req_o1, we_o1, req_o2, we_o2;
  logic [31:0] addr_o1, wdata_o1, rdata_i1, addr_o2, wdata_o2, rdata_i2, rd2a;
  logic [3:0] be_o1, be_o2;
  logic [31:0] mem1 [256];
  logic [31:0] mem2 [256];
  int n_cmp = 0;
  int n_err = 0;

  obi_sram_shim #(.ObiCfg(Cfg1), .SramLatency(1), .RspFifoDepth(2)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .obi_req_i(q1), .obi_rsp_o(s1), .req_o(req_o1),
    .we_o(we_o1), .addr_o(addr_o1), .wdata_o(wdata_o1), .be_o(be_o1), .rdata_i(rdata_i1)
  );

  obi_sram_shim #(.ObiCfg(ObiDefaultConfig), .SramLatency(2), .RspFifoDepth(3)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .obi_req_i(q2), .obi_rsp_o(s2), .req_o(req_o2),
    .we_o(we_o2), .addr_o(addr_o2), .wdata_o(wdata_o2), .be_o(be_o2), .rdata_i(rdata_i2)
  );

  // SRAM model with 1-cycle read latency
  always @(posedge clk) begin
    if (req_o1) begin
      if (we_o1) begin
        for (int b = 0; b < 4; b++)
          if (be_o1[b]) mem1[addr_o1[9:2]][8*b +: 8] <= wdata_o1[8*b +: 8];
      end else rdata_i1 <= mem1[addr_o1[9:2]];
    end
  end

  // SRAM model with 2-cycle read latency
  always @(posedge clk) begin
    if (req_o2 && !we_o2) rd2a <= mem2[addr_o2[9:2]];
    rdata_i2 <= rd2a;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    q1 = '0; q2 = '0;
    q1.req = 1'b1; q2.req = 1'b1; q1.rready = 1'b1; q2.rready = 1'b1;
    #3;
    n_cmp++;
    if ({s1.gnt, s1.rvalid, s1.r.rdata, s1.r.rid, s1.r.err, req_o1, we_o1} !== 41'h0) begin
      n_err++;
      $display("FAIL reset_dut1: got %h want 0", {s1.gnt, s1.rvalid, s1.r.rdata, s1.r.rid, s1.r.err, req_o1, we_o1});
    end
    n_cmp++;
    if ({s2.gnt, s2.rvalid, s2.r.rdata, s2.r.rid, s2.r.err, req_o2, we_o2} !== 41'h0) begin
      n_err++;
      $display("FAIL reset_dut2: got %h want 0", {s2.gnt, s2.rvalid, s2.r.rdata, s2.r.rid, s2.r.err, req_o2, we_o2});
    end
    q1.req = 1'b0; q2.req = 1'b0;
    tick; tick;
    rst_n = 1'b1;
  endtask

  task automatic test_single_read;
    tick;
    q1.req = 1'b1; q1.a = '0; q1.a.addr = 32'h100; q1.a.aid = 4'd3; q1.a.be = 4'hF;
    #3;
    n_cmp++;
    if ({s1.gnt, req_o1, we_o1, addr_o1, s1.rvalid} !== {1'b1, 1'b1, 1'b0, 32'h100, 1'b0}) begin
      n_err++;
      $display("FAIL read_issue: got %h want %h", {s1.gnt, req_o1, we_o1, addr_o1, s1.rvalid}, {1'b1, 1'b1, 1'b0, 32'h100, 1'b0});
    end
    tick;
    q1.req = 1'b0;
    #3;
    n_cmp++;
    if ({s1.rvalid, s1.r.rdata, s1.r.rid, s1.r.err} !== {1'b1, 32'hDEADBEEF, 4'd3, 1'b0}) begin
      n_err++;
      $display("FAIL read_rsp: got %h want %h", {s1.rvalid, s1.r.rdata, s1.r.rid, s1.r.err}, {1'b1, 32'hDEADBEEF, 4'd3, 1'b0});
    end
    tick;
    #3;
    n_cmp++;
    if (s1.rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL read_drained: got rvalid %b want 0", s1.rvalid);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_d;
    logic [3:0] exp_id;
    for (int k = 0; k < 18; k++) begin
      tick;
      if (k < 16) begin
        q2.req = 1'b1; q2.a = '0; q2.a.addr = 32'(4 * k); q2.a.aid = 4'(k); q2.a.be = 4'hF;
      end else q2.req = 1'b0;
      #3;
      if (k < 16) begin
        n_cmp++;
        if (s2.gnt !== 1'b1) begin
          n_err++;
          $display("FAIL b2b_gnt[%0d]: got %b want 1", k, s2.gnt);
        end
      end
      if (k >= 2) begin
        exp_d = 32'hC0DE0000 + 32'(k - 2);
        exp_id = 4'(k - 2);
        n_cmp++;
        if ({s2.rvalid, s2.r.rdata, s2.r.rid, s2.r.err} !== {1'b1, exp_d, exp_id, 1'b0}) begin
          n_err++;
          $display("FAIL b2b_rsp[%0d]: got %h want %h", k, {s2.rvalid, s2.r.rdata, s2.r.rid, s2.r.err}, {1'b1, exp_d, exp_id, 1'b0});
        end
      end else begin
        n_cmp++;
        if (s2.rvalid !== 1'b0) begin
          n_err++;
          $display("FAIL b2b_early[%0d]: got rvalid %b want 0", k, s2.rvalid);
        end
      end
    end
    tick;
    #3;
    n_cmp++;
    if (s2.rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_tail: got rvalid %b want 0", s2.rvalid);
    end
  endtask

  task automatic test_backpressure;
    q1.rready = 1'b0;
    tick;
    q1.req = 1'b1; q1.a = '0; q1.a.be = 4'hF; q1.a.addr = 32'h0; q1.a.aid = 4'd1;
    #3;
    n_cmp++;
    if (s1.gnt !== 1'b1) begin
      n_err++;
      $display("FAIL bp_gnt0: got %b want 1", s1.gnt);
    end
    tick;
    q1.a.addr = 32'h4; q1.a.aid = 4'd2;
    #3;
    n_cmp++;
    if ({s1.gnt, s1.rvalid, s1.r.rdata, s1.r.rid} !== {1'b1, 1'b1, 32'hC0DE0000, 4'd1}) begin
      n_err++;
      $display("FAIL bp_c1: got %h want %h", {s1.gnt, s1.rvalid, s1.r.rdata, s1.r.rid}, {1'b1, 1'b1, 32'hC0DE0000, 4'd1});
    end
    tick;
    q1.a.addr = 32'h8; q1.a.aid = 4'd3;
    for (int c = 0; c < 2; c++) begin
      #3;
      n_cmp++;
      if ({s1.gnt, s1.rvalid, s1.r.rdata, s1.r.rid} !== {1'b0, 1'b1, 32'hC0DE0000, 4'd1}) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: got %h want %h", c, {s1.gnt, s1.rvalid, s1.r.rdata, s1.r.rid}, {1'b0, 1'b1, 32'hC0DE0000, 4'd1});
      end
      if (c == 0) tick;
    end
    q1.rready = 1'b1;
    tick;
    #3;
    n_cmp++;
    if ({s1.gnt, s1.rvalid, s1.r.rdata, s1.r.rid} !== {1'b1, 1'b1, 32'hC0DE0001, 4'd2}) begin
      n_err++;
      $display("FAIL bp_drain1: got %h want %h", {s1.gnt, s1.rvalid, s1.r.rdata, s1.r.rid}, {1'b1, 1'b1, 32'hC0DE0001, 4'd2});
    end
    tick;
    q1.req = 1'b0;
    #3;
    n_cmp++;
    if ({s1.rvalid, s1.r.rdata, s1.r.rid} !== {1'b1, 32'hC0DE0002, 4'd3}) begin
      n_err++;
      $display("FAIL bp_drain2: got %h want %h", {s1.rvalid, s1.r.rdata, s1.r.rid}, {1'b1, 32'hC0DE0002, 4'd3});
    end
    tick;
    #3;
    n_cmp++;
    if (s1.rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_empty: got rvalid %b want 0", s1.rvalid);
    end
  endtask

  task automatic test_write;
    tick;
    q1.req = 1'b1; q1.a = '0; q1.a.we = 1'b1; q1.a.be = 4'h3; q1.a.wdata = 32'hA5A5A5A5;
    q1.a.addr = 32'h200; q1.a.aid = 4'd5;
    #3;
    n_cmp++;
    if ({s1.gnt, req_o1, we_o1, be_o1, wdata_o1} !== {1'b1, 1'b1, 1'b1, 4'h3, 32'hA5A5A5A5}) begin
      n_err++;
      $display("FAIL wr_issue: got %h want %h", {s1.gnt, req_o1, we_o1, be_o1, wdata_o1}, {1'b1, 1'b1, 1'b1, 4'h3, 32'hA5A5A5A5});
    end
    tick;
    q1.req = 1'b0;
    #3;
    n_cmp++;
    if ({s1.rvalid, s1.r.rdata, s1.r.rid, s1.r.err} !== {1'b1, 32'h0, 4'd5, 1'b0}) begin
      n_err++;
      $display("FAIL wr_rsp: got %h want %h", {s1.rvalid, s1.r.rdata, s1.r.rid, s1.r.err}, {1'b1, 32'h0, 4'd5, 1'b0});
    end
    tick;
    q1.req = 1'b1; q1.a = '0; q1.a.be = 4'hF; q1.a.addr = 32'h200; q1.a.aid = 4'd6;
    #3;
    tick;
    q1.req = 1'b0;
    #3;
    n_cmp++;
    if ({s1.rvalid, s1.r.rdata, s1.r.rid} !== {1'b1, 32'hC0DEA5A5, 4'd6}) begin
      n_err++;
      $display("FAIL wr_readback: got %h want %h", {s1.rvalid, s1.r.rdata, s1.r.rid}, {1'b1, 32'hC0DEA5A5, 4'd6});
    end
  endtask

  task automatic test_atomic;
    tick;
    q1.req = 1'b1; q1.a = '0; q1.a.be = 4'hF; q1.a.addr = 32'h100; q1.a.aid = 4'd7; q1.a.atop = 6'h21;
    #3;
    n_cmp++;
    if ({s1.gnt, req_o1, we_o1} !== {1'b1, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL atop_issue: got %b want 100", {s1.gnt, req_o1, we_o1});
    end
    tick;
    q1.req = 1'b0; q1.a.atop = 6'h0;
    #3;
    n_cmp++;
    if ({s1.rvalid, s1.r.rdata, s1.r.rid, s1.r.err, s1.r.exokay} !== {1'b1, 32'h0, 4'd7, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL atop_rsp: got %h want %h", {s1.rvalid, s1.r.rdata, s1.r.rid, s1.r.err, s1.r.exokay}, {1'b1, 32'h0, 4'd7, 1'b1, 1'b0});
    end
  endtask

  task automatic test_async_reset;
    tick;
    q1.rready = 1'b0;
    q1.req = 1'b1; q1.a = '0; q1.a.be = 4'hF; q1.a.addr = 32'h0; q1.a.aid = 4'd1;
    #3;
    tick;
    q1.a.addr = 32'h4; q1.a.aid = 4'd2;
    #3;
    n_cmp++;
    if ({s1.gnt, s1.rvalid} !== 2'b11) begin
      n_err++;
      $display("FAIL ar_fill: got %b want 11", {s1.gnt, s1.rvalid});
    end
    tick;
    q1.a.addr = 32'h8; q1.a.aid = 4'd3;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({s1.gnt, s1.rvalid, req_o1} !== 3'b000) begin
      n_err++;
      $display("FAIL ar_assert: got %b want 000", {s1.gnt, s1.rvalid, req_o1});
    end
    q1.req = 1'b0; q1.rready = 1'b1;
    tick; tick;
    rst_n = 1'b1;
    tick;
    q1.req = 1'b1; q1.a = '0; q1.a.be = 4'hF; q1.a.addr = 32'h100; q1.a.aid = 4'd4;
    #3;
    n_cmp++;
    if ({s1.gnt, s1.rvalid} !== 2'b10) begin
      n_err++;
      $display("FAIL ar_regrant: got %b want 10", {s1.gnt, s1.rvalid});
    end
    tick;
    q1.req = 1'b0;
    #3;
    n_cmp++;
    if ({s1.rvalid, s1.r.rdata, s1.r.rid, s1.r.err} !== {1'b1, 32'hDEADBEEF, 4'd4, 1'b0}) begin
      n_err++;
      $display("FAIL ar_rsp: got %h want %h", {s1.rvalid, s1.r.rdata, s1.r.rid, s1.r.err}, {1'b1, 32'hDEADBEEF, 4'd4, 1'b0});
    end
    tick;
    #3;
    n_cmp++;
    if (s1.rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL ar_no_stale: got rvalid %b want 0", s1.rvalid);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem1[i] = 32'hC0DE0000 + 32'(i);
      mem2[i] = 32'hC0DE0000 + 32'(i);
    end
    mem1[8'h40] = 32'hDEADBEEF;
    test_reset;
    test_single_read;
    test_back_to_back;
    test_backpressure;
    test_write;
    test_atomic;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
